uart_tx_dp: RTL and testbench

UART transmit datapath and sequencing registers for the D9 UART: holds the bit counter state, generates the per-bit `baud_clk` tick from the programmed `baud` divisor, captures the transmit byte, and drives the serial `tx` line. It sits directly downstream of the combinational TX control path `tx_cp`. It registers `tx_cp`'s next-state count `bit_cntn` into `bit_cnto` and consumes `tx_en`. It feeds `bit_cnto` and `baud_clk` back to `tx_cp`.

---
 rtl/uart_tx_dp.sv | 85 ++++++++
 tb/tb_uart_tx_dp.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_dp.sv
// Purpose: UART TX datapath (bit index register, baud divider, byte capture, serial line) under tx_cp.
// Latency: bit_cnto registers bit_cntn in 1 cycle; tx lags bit_cnto by 1 cycle; baud_clk/busy/done are decodes.
// Backpressure: none; tx_cp paces the frame through tx_en/bit_cntn and aborts by dropping tx_en.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous reset, active low
//   baud      clock cycles per bit (20 bits)
//   din       byte to transmit, sampled at the start of a frame
//   tx_en     frame in progress (from tx_cp)
//   bit_cntn  next bit index (from tx_cp)
//   bit_cnto  registered bit index (to tx_cp)
//   baud_clk  one-cycle bit-boundary tick (to tx_cp)
//   tx        registered serial line, idles high
//   busy      frame in progress (= tx_en)
//   done      bit index reached 10, frame complete
module uart_tx_dp (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] baud,
  input  logic [7:0]  din,
  input  logic        tx_en,
  input  logic [9:0]  bit_cntn,
  output logic [9:0]  bit_cnto,
  output logic        baud_clk,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  logic [19:0] baud_cnt;
  logic [19:0] baud_m1;
  logic        bit_end;
  logic [7:0]  din_q;
  logic [2:0]  data_idx;
  logic        tx_nxt;

  // baud < 15 never reaches here with tx_en high, so the wrap of baud-1 is harmless.
  assign baud_m1  = baud - 20'd1;
  // >= rather than == so a mid-frame baud decrease costs at most one short bit.
  assign bit_end  = (baud_cnt >= baud_m1);
  assign baud_clk = tx_en & bit_end;

  assign busy = tx_en;
  assign done = (bit_cnto == 10'd10);

  // Data bit for bit index 1..8 is din_q[index-1]; index 8 wraps to 7 in 3 bits.
  assign data_idx = bit_cnto[2:0] - 3'd1;

  always_comb begin
    tx_nxt = 1'b1;
    if (tx_en) begin
      if (bit_cnto == 10'd0) begin
        tx_nxt = 1'b0;
      end else if (bit_cnto <= 10'd8) begin
        tx_nxt = din_q[data_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnto <= 10'd0;
      baud_cnt <= 20'd0;
      din_q    <= 8'h00;
      tx       <= 1'b1;
    end else begin
      bit_cnto <= bit_cntn;

      if (!tx_en || bit_end) begin
        baud_cnt <= 20'd0;
      end else begin
        baud_cnt <= baud_cnt + 20'd1;
      end

      // Tracks din while idle; the last sample is taken on the edge ending frame cycle 0.
      if (bit_cnto == 10'd0 && baud_cnt == 20'd0) begin
        din_q <= din;
      end

      tx <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_dp.sv
module tb_uart_tx_dp;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] baud;
  logic [7:0]  din;
  logic        tx_en;
  logic [9:0]  bit_cntn;
  logic [9:0]  bit_cnto;
  logic        baud_clk;
  logic        tx;
  logic        busy;
  logic        done;

  // tx_cp-side controls
  logic        set;
  logic        sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_dp dut (
    .clk      (clk),
    .rst      (rst),
    .baud     (baud),
    .din      (din),
    .tx_en    (tx_en),
    .bit_cntn (bit_cntn),
    .bit_cnto (bit_cnto),
    .baud_clk (baud_clk),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  // Minimal stand-in for the upstream control path.
  always_comb begin
    tx_en = rst & set & sel & (baud >= 20'd15) & (bit_cnto != 10'd10);
  end

  always_comb begin
    bit_cntn = bit_cnto;
    if (!rst || !set || !sel) begin
      bit_cntn = 10'd0;
    end else if (baud_clk) begin
      bit_cntn = bit_cnto + 10'd1;
    end
  end

  // Reference: frame behaviour as a function of frame cycle c (cycle 0 = first tx_en cycle).
  function automatic logic exp_tx(input int c, input int b, input logic [7:0] d);
    int k;
    if (c < 1 || c > 10 * b) return 1'b1;
    k = (c - 1) / b;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return d[k-1];
  endfunction

  function automatic int exp_cnt(input int c, input int b);
    int k;
    k = c / b;
    return (k > 10) ? 10 : k;
  endfunction

  function automatic logic exp_bclk(input int c, input int b);
    return (c < 10 * b) && (((c + 1) % b) == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic e_tx, input int e_cnt,
                         input logic e_bclk, input logic e_busy, input logic e_done);
    chk({tag, ".tx"},       {31'd0, tx},       {31'd0, e_tx});
    chk({tag, ".bit_cnto"}, {22'd0, bit_cnto}, e_cnt);
    chk({tag, ".baud_clk"}, {31'd0, baud_clk}, {31'd0, e_bclk});
    chk({tag, ".busy"},     {31'd0, busy},     {31'd0, e_busy});
    chk({tag, ".done"},     {31'd0, done},     {31'd0, e_done});
  endtask

  // mode 0: complete frame, hold set for tail cycles past completion, then drop set 1 cycle.
  // mode 1: set dropped at cycle cut.  mode 2: rst low at cycles cut and cut+1, set stays high.
  task automatic run_frame(input string tag, input logic [7:0] d, input int b,
                           input int mode, input int cut, input int tail);
    int last;
    last = (mode == 0) ? 10 * b + tail : cut + 1;
    for (int c = 0; c <= last; c++) begin
      rst  = !(mode == 2 && (c == cut || c == cut + 1));
      set  = !(mode == 1 && c >= cut);
      sel  = 1'b1;
      baud = 20'(b);
      din  = (c == 0) ? d : 8'($urandom);
      #1;
      if (mode != 0 && c > cut) begin
        chk_all(tag, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        if (mode == 1) chk({tag, ".baud_cnt"}, {12'd0, dut.baud_cnt}, 32'd0);
      end else if (mode != 0 && c == cut) begin
        chk_all(tag, exp_tx(c, b, d), exp_cnt(c, b), 1'b0, 1'b0, 1'b0);
      end else begin
        chk_all(tag, exp_tx(c, b, d), exp_cnt(c, b), exp_bclk(c, b),
                c < 10 * b, c >= 10 * b);
      end
      next_cycle();
    end
    if (mode == 0) begin
      set = 1'b0;
      din = 8'($urandom);
      #1;
      chk_all({tag, ".drop"}, 1'b1, 10, 1'b0, 1'b0, 1'b1);
      next_cycle();
    end
  endtask

  initial begin
    logic [7:0] rd;
    int         rb;
    int         rm;

    // Reset with random inputs
    rst = 1'b0; set = 1'b0; sel = 1'b0; baud = 20'd16; din = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      set  = 1'($urandom);
      sel  = 1'($urandom);
      baud = 20'($urandom);
      din  = 8'($urandom);
      #1;
      chk_all("reset", 1'b1, 0, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1; set = 1'b0; sel = 1'b1; baud = 20'd16;
    next_cycle();
    next_cycle();

    // Nominal frame, then back-to-back with a new byte presented as set rises
    run_frame("nominal", 8'hA5, 16, 0, 0, 20);
    run_frame("b2b",     8'h3C, 16, 0, 0, 2);

    // Abort at cycle 50
    run_frame("abort",   8'hA5, 16, 1, 50, 0);

    // Reset mid-frame, restart immediately with set still high
    run_frame("rst_mid", 8'hA5, 16, 2, 80, 0);
    run_frame("restart", 8'h5A, 16, 0, 0, 0);

    // Invalid baud: the frame never starts
    for (int c = 0; c < 300; c++) begin
      rst = 1'b1; set = 1'b1; sel = 1'b1; baud = 20'd14; din = 8'($urandom);
      #1;
      chk_all("bad_baud", 1'b1, 0, 1'b0, 1'b0, 1'b0);
      next_cycle();
    end
    set = 1'b0;
    baud = 20'd16;
    next_cycle();

    // Random frames: random byte, baud, and ending
    for (int n = 0; n < 8; n++) begin
      rd = 8'($urandom);
      rb = int'($urandom_range(15, 24));
      rm = int'($urandom_range(0, 2));
      run_frame("random", rd, rb, rm, int'($urandom_range(1, 10 * rb - 1)),
                int'($urandom_range(0, 5)));
    end
    run_frame("final", 8'h81, 15, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a hung simulation
  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
